// File: rtl/shape_pkg.sv
// Shared board/shape types and constants for the move/lock/clear path.
package shape_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;

    typedef struct packed {
        logic [2:0] kind;
        logic [1:0] rot;
        logic [4:0] shapeRowPos;
        logic [3:0] shapeColPos;
    } shapeStruct;

    typedef logic [BOARD_ROWS-1:0][BOARD_COLS-1:0] board_t;

    // Points per pass indexed by min(lines, 4).
    localparam logic [4:0][10:0] SCORE_TBL = {11'd1200, 11'd300, 11'd100, 11'd40, 11'd0};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        DONE
    } line_clear_state_t;

endpackage

// File: rtl/board_collapse.sv
// Combinational row removal: drops board[row], pulls every higher row down one, zero-fills the top.
module board_collapse #(
    parameter int ROWS  = 20,
    parameter int COLS  = 10,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic [ROWS-1:0][COLS-1:0] board,
    input  logic [ROW_W-1:0]          row,
    output logic [ROWS-1:0][COLS-1:0] collapsed
);

    always_comb begin
        collapsed = '0;
        for (int i = 0; i < ROWS - 1; i++) begin
            collapsed[i] = (i >= int'(row)) ? board[i+1] : board[i];
        end
    end

endmodule

// File: rtl/line_clear.sv
// Bottom-up full-row scanner/collapser for the locked board.
// Optional LINE_CLEAR_SCORE_EN adds a saturating 20-bit score output.
module line_clear
    import shape_pkg::*;
#(
    parameter int ROWS  = BOARD_ROWS,
    parameter int COLS  = BOARD_COLS,
    parameter int CNT_W = $clog2(ROWS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ROWS-1:0][COLS-1:0] screen,
    output logic                      busy,
    output logic                      done,
    output logic [ROWS-1:0][COLS-1:0] outputScreen,
    output logic [CNT_W-1:0]          linesCleared,
`ifdef LINE_CLEAR_SCORE_EN
    output logic [19:0]               score,
`endif
    output logic [15:0]               totalLines
);

    localparam int ROW_W = $clog2(ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    line_clear_state_t state, state_next;

    logic [ROWS-1:0][COLS-1:0] board;
    logic [ROWS-1:0][COLS-1:0] collapsed;
    logic [ROW_W-1:0]          row;
    logic [CNT_W-1:0]          count;
    logic                      row_full;

    function automatic logic [15:0] sat16(input logic [15:0] acc, input logic [CNT_W-1:0] add);
        logic [16:0] sum;
        sum = {1'b0, acc} + 17'(add);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

`ifdef LINE_CLEAR_SCORE_EN
    function automatic logic [19:0] sat20(input logic [19:0] acc, input logic [10:0] add);
        logic [20:0] sum;
        sum = {1'b0, acc} + 21'(add);
        return sum[20] ? 20'hFFFFF : sum[19:0];
    endfunction

    function automatic logic [10:0] pass_points(input logic [CNT_W-1:0] n);
        logic [2:0] idx;
        idx = (n > CNT_W'(4)) ? 3'd4 : n[2:0];
        return SCORE_TBL[idx];
    endfunction
`endif

    assign row_full = &board[row];

    board_collapse #(
        .ROWS (ROWS),
        .COLS (COLS),
        .ROW_W(ROW_W)
    ) u_collapse (
        .board    (board),
        .row      (row),
        .collapsed(collapsed)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = SCAN;
            SCAN: begin
                if (row_full)             state_next = SHIFT;
                else if (row == LAST_ROW) state_next = DONE;
            end
            // Rescan the same row afterwards so stacked full rows are caught.
            SHIFT: state_next = SCAN;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            board        <= '0;
            row          <= '0;
            count        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            outputScreen <= '0;
            linesCleared <= '0;
            totalLines   <= '0;
`ifdef LINE_CLEAR_SCORE_EN
            score        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        board <= screen;
                        row   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (!row_full && row != LAST_ROW) row <= row + ROW_W'(1);
                end
                SHIFT: begin
                    board <= collapsed;
                    count <= count + CNT_W'(1);
                end
                DONE: begin
                    outputScreen <= board;
                    linesCleared <= count;
                    totalLines   <= sat16(totalLines, count);
`ifdef LINE_CLEAR_SCORE_EN
                    score        <= sat20(score, pass_points(count));
`endif
                    done         <= 1'b1;
                    busy         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear.sv
// Directed bench for line_clear: latency, collapse results, counters, ignored start, mid-pass reset.
module tb_line_clear;

    localparam int R  = 20;
    localparam int C  = 10;
    localparam int CW = 5;
    localparam int BW = R * C;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [R-1:0][C-1:0] screen;
    logic                busy;
    logic                done;
    logic [R-1:0][C-1:0] out_screen;
    logic [CW-1:0]       lines;
    logic [15:0]         total;
`ifdef LINE_CLEAR_SCORE_EN
    logic [19:0]         score;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_clear dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .screen      (screen),
        .busy        (busy),
        .done        (done),
        .outputScreen(out_screen),
        .linesCleared(lines),
`ifdef LINE_CLEAR_SCORE_EN
        .score       (score),
`endif
        .totalLines  (total)
    );

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start with board b; lat counts edges from the start edge to done (-1 on timeout).
    task automatic run_pass(input logic [R-1:0][C-1:0] b, output int lat);
        screen = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        screen = '0;
        lat    = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
        if (!done) lat = -1;
    endtask

    logic [R-1:0][C-1:0] b, e;
    int lat, nd, dc;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        screen = '0;
        tick();
        tick();
        check("rst_busy", BW'(busy), BW'(1'b0));
        check("rst_done", BW'(done), BW'(1'b0));
        check("rst_screen", BW'(out_screen), BW'(0));
        check("rst_lines", BW'(lines), BW'(0));
        check("rst_total", BW'(total), BW'(0));
`ifdef LINE_CLEAR_SCORE_EN
        check("rst_score", BW'(score), BW'(0));
`endif
        reset = 1'b0;
        tick();

        // Empty board
        b = '0;
        run_pass(b, lat);
        check("empty_lat", BW'(lat), BW'(21));
        check("empty_lines", BW'(lines), BW'(0));
        check("empty_screen", BW'(out_screen), BW'(0));
        check("empty_total", BW'(total), BW'(0));
        tick();
        check("empty_done_pulse", BW'(done), BW'(1'b0));
        check("empty_busy_after", BW'(busy), BW'(1'b0));

        // Single full bottom row
        b = '0; b[0] = 10'h3FF; b[1] = 10'h201;
        e = '0; e[0] = 10'h201;
        run_pass(b, lat);
        check("one_lat", BW'(lat), BW'(23));
        check("one_screen", BW'(out_screen), BW'(e));
        check("one_lines", BW'(lines), BW'(1));
        check("one_total", BW'(total), BW'(1));

        // Four stacked rows
        reset = 1'b1; tick(); reset = 1'b0; tick();
        b = '0; b[0] = 10'h3FF; b[1] = 10'h3FF; b[2] = 10'h3FF; b[3] = 10'h3FF; b[4] = 10'h0F0;
        e = '0; e[0] = 10'h0F0;
        run_pass(b, lat);
        check("four_lat", BW'(lat), BW'(29));
        check("four_screen", BW'(out_screen), BW'(e));
        check("four_lines", BW'(lines), BW'(4));
        check("four_total", BW'(total), BW'(4));
`ifdef LINE_CLEAR_SCORE_EN
        check("four_score", BW'(score), BW'(1200));
`endif

        // Split rows, two back-to-back passes
        reset = 1'b1; tick(); reset = 1'b0; tick();
        b = '0; b[2] = 10'h3FF; b[5] = 10'h3FF; b[3] = 10'h001; b[6] = 10'h100;
        e = '0; e[2] = 10'h001; e[4] = 10'h100;
        run_pass(b, lat);
        check("split_lat", BW'(lat), BW'(25));
        check("split_screen", BW'(out_screen), BW'(e));
        check("split_lines", BW'(lines), BW'(2));
        check("split_total1", BW'(total), BW'(2));
`ifdef LINE_CLEAR_SCORE_EN
        check("split_score1", BW'(score), BW'(100));
`endif
        run_pass(b, lat);
        check("split_screen2", BW'(out_screen), BW'(e));
        check("split_total2", BW'(total), BW'(4));
`ifdef LINE_CLEAR_SCORE_EN
        check("split_score2", BW'(score), BW'(200));
`endif

        // Top row full, with an ignored start (and a changed screen) at cycle 5
        b = '0; b[19] = 10'h3FF;
        screen = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        nd = 0; dc = -1;
        for (int c = 1; c <= 30; c++) begin
            start  = (c == 5);
            screen = (c == 5) ? '1 : '0;
            tick();
            if (done) begin
                nd++;
                dc = c;
            end
        end
        start = 1'b0; screen = '0;
        check("top_done_count", BW'(nd), BW'(1));
        check("top_done_cycle", BW'(dc), BW'(23));
        check("top_screen", BW'(out_screen), BW'(0));
        check("top_lines", BW'(lines), BW'(1));
        check("top_total", BW'(total), BW'(5));

        // Reset mid-pass
        b = '0; b[0] = 10'h3FF;
        screen = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("mid_busy_before", BW'(busy), BW'(1'b1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_busy", BW'(busy), BW'(1'b0));
        check("mid_done", BW'(done), BW'(1'b0));
        check("mid_screen", BW'(out_screen), BW'(0));
        check("mid_lines", BW'(lines), BW'(0));
        check("mid_total", BW'(total), BW'(0));
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done) nd++;
        end
        check("mid_no_done", BW'(nd), BW'(0));
        b = '0; b[0] = 10'h3FF; b[1] = 10'h201;
        e = '0; e[0] = 10'h201;
        run_pass(b, lat);
        check("post_lat", BW'(lat), BW'(23));
        check("post_screen", BW'(out_screen), BW'(e));
        check("post_total", BW'(total), BW'(1));

        // Fully filled board
        b = '1;
        run_pass(b, lat);
        check("full_lat", BW'(lat), BW'(61));
        check("full_screen", BW'(out_screen), BW'(0));
        check("full_lines", BW'(lines), BW'(20));
        check("full_total", BW'(total), BW'(21));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
